// File: rtl/ic_download_pkg.sv
// Shared constants, header field layout and state encoding for the instruction-reply
// download stage in front of the instruction cache.
package ic_download_pkg;

  localparam int FLIT_W     = 16;
  localparam int DATA_FLITS = 8;
  localparam int BLK_W      = FLIT_W * DATA_FLITS;
  localparam int CNT_W      = 3;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_FLITS - 1);

  // Header: [15:14] source id, [13:9] cmd, [8:0] reserved.
  localparam int SRC_LSB = 14;
  localparam int SRC_W   = 2;
  localparam int CMD_LSB = 9;
  localparam int CMD_W   = 5;

  localparam logic [CMD_W-1:0] INSTREP_CMD = 5'b10110;
  localparam logic [CMD_W-1:0] INSTREQ_CMD = 5'b00110;
  localparam logic [SRC_W-1:0] LOCAL_ID    = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [BLK_W-1:0] blk;
  } pend_t;

  function automatic logic [CMD_W-1:0] hdr_cmd(input logic [FLIT_W-1:0] f);
    return f[CMD_LSB +: CMD_W];
  endfunction

endpackage

// File: rtl/ic_flit_asm.sv
// Beat counter and 128-bit assembly buffer: data flit k lands in blk[k*16 +: 16].
// blk_next_o exposes the buffer including the flit being written this cycle.
module ic_flit_asm
  import ic_download_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [FLIT_W-1:0] flit_i,
  output logic              last_o,
  output logic [BLK_W-1:0]  blk_next_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_q, blk_d;

  // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    blk_d = blk_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wr_i) begin
      blk_d[cnt_q*FLIT_W +: FLIT_W] = flit_i;
      cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the buffer is plain flops, not a RAM, so it is reset like any other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      blk_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      blk_q <= blk_d;
    end
  end

  assign last_o     = (cnt_q == LAST_BEAT);
  assign blk_next_o = blk_d;

endmodule

// File: rtl/ic_download.sv
// Instruction-reply download stage: header/body/done FSM, error pulse and output merge.
// Define IC_DOWNLOAD_LOCAL_EN to compile in the local-memory bypass with its pending register.
module ic_download
  import ic_download_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              v_flit,
  input  logic [FLIT_W-1:0] flit,
  output logic              flit_rdy,
  input  logic              v_mem_4word,
  input  logic [BLK_W-1:0]  mem_4word,
  output logic              v_inst_4word,
  output logic [BLK_W-1:0]  inst_4word,
  output logic              dn_err
);

  state_e state_q, state_d;

  logic             flit_acc, hdr_ok, hdr_acc, beat_wr, beat_last, net_fire;
  logic [BLK_W-1:0] asm_blk;
  logic             v_inst_q, v_inst_d, dn_err_q, dn_err_d;
  logic [BLK_W-1:0] inst_q, inst_d;

  assign flit_acc = v_flit & flit_rdy;
  assign hdr_ok   = (hdr_cmd(flit) == INSTREP_CMD);
  assign hdr_acc  = flit_acc & (state_q == ST_IDLE);
  assign beat_wr  = flit_acc & (state_q == ST_BODY);
  assign net_fire = beat_wr & beat_last;

  ic_flit_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (hdr_acc & hdr_ok),
    .wr_i      (beat_wr),
    .flit_i    (flit),
    .last_o    (beat_last),
    .blk_next_o(asm_blk)
  );

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hdr_acc && hdr_ok) state_d = ST_BODY;
      ST_BODY: if (net_fire)          state_d = ST_DONE;
      ST_DONE:                        state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Ready depends on the state register only, never on inputs.
  always_comb begin
    flit_rdy = (state_q != ST_DONE);
  end

`ifdef IC_DOWNLOAD_LOCAL_EN
  pend_t pend_q, pend_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= pend_d;
  end
`else
  logic unused_mem;
  assign unused_mem = ^{v_mem_4word, mem_4word};
`endif

  // The network block always wins the strobe slot; a colliding local block waits one cycle.
  always_comb begin
    v_inst_d = 1'b0;
    inst_d   = inst_q;
    dn_err_d = hdr_acc & ~hdr_ok;
`ifdef IC_DOWNLOAD_LOCAL_EN
    pend_d   = pend_q;
`endif
    if (net_fire) begin
      v_inst_d = 1'b1;
      inst_d   = asm_blk;
`ifdef IC_DOWNLOAD_LOCAL_EN
      if (v_mem_4word) pend_d = '{valid: 1'b1, blk: mem_4word};
    end else if (v_mem_4word || pend_q.valid) begin
      v_inst_d     = 1'b1;
      inst_d       = v_mem_4word ? mem_4word : pend_q.blk;
      pend_d.valid = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_inst_q <= 1'b0;
      inst_q   <= '0;
      dn_err_q <= 1'b0;
    end else begin
      v_inst_q <= v_inst_d;
      inst_q   <= inst_d;
      dn_err_q <= dn_err_d;
    end
  end

  assign v_inst_4word = v_inst_q;
  assign inst_4word   = inst_q;
  assign dn_err       = dn_err_q;

endmodule

// File: tb/tb_ic_download.sv
// Self-checking bench for ic_download: directed and randomized replies, local pulses and
// mid-message reset, checked cycle by cycle against an expected-event schedule.
module tb_ic_download;

`ifdef IC_DOWNLOAD_LOCAL_EN
  localparam bit LOCAL_EN = 1'b1;
`else
  localparam bit LOCAL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         v_flit = 1'b0;
  logic [15:0]  flit = '0;
  logic         flit_rdy;
  logic         v_mem = 1'b0;
  logic [127:0] mem = '0;
  logic         v_inst;
  logic [127:0] inst;
  logic         dn_err;

  ic_download dut (
    .clk         (clk),
    .rst         (rst),
    .v_flit      (v_flit),
    .flit        (flit),
    .flit_rdy    (flit_rdy),
    .v_mem_4word (v_mem),
    .mem_4word   (mem),
    .v_inst_4word(v_inst),
    .inst_4word  (inst),
    .dn_err      (dn_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected-event schedule keyed by cycle number.
  logic [127:0] exp_blk [int];
  bit           exp_err [int];
  bit           exp_done[int];
  logic [127:0] exp_last = '0;
  bit           mon_en = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void expect_local(input int m, input logic [127:0] d);
    int slot;
    if (!LOCAL_EN) return;
    slot = m + 1;
    if (exp_done.exists(slot)) slot++;
    exp_blk[slot] = d;
  endfunction

  // Per-cycle comparison of every output against the schedule.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      bit v_exp;
      v_exp = exp_blk.exists(cyc) ? 1'b1 : 1'b0;
      if (v_exp) exp_last = exp_blk[cyc];
      check("v_inst", 128'(v_inst), 128'(v_exp));
      check("inst", inst, exp_last);
      check("dn_err", 128'(dn_err), 128'(exp_err.exists(cyc) ? 1'b1 : 1'b0));
      check("flit_rdy", 128'(flit_rdy), 128'(exp_done.exists(cyc) ? 1'b0 : 1'b1));
    end
  end

  // Sends header then 8 data flits with 'gap' idle cycles before each data flit; returns
  // in the cycle after the last accepted flit.
  task automatic send_msg(input logic [15:0] hdr, input logic [127:0] blk, input int gap,
                          input bit mem_last, input logic [127:0] mblk);
    int hc, lc;
    step();
    v_flit = 1'b1;
    flit   = hdr;
    hc     = cyc;
    if (hdr[13:9] != 5'b10110) begin
      exp_err[hc+1] = 1'b1;
      step();
      v_flit = 1'b0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        step();
        v_flit = 1'b0;
        flit   = 16'($urandom);
      end
      step();
      v_flit = 1'b1;
      flit   = blk[i*16 +: 16];
    end
    lc = cyc;
    exp_blk[lc+1]  = blk;
    exp_done[lc+1] = 1'b1;
    if (mem_last) begin
      v_mem = 1'b1;
      mem   = mblk;
      expect_local(lc, mblk);
    end
    step();
    v_flit = 1'b0;
    v_mem  = 1'b0;
  endtask

  task automatic mem_pulse_now(input logic [127:0] d);
    v_mem = 1'b1;
    mem   = d;
    expect_local(cyc, d);
    step();
    v_mem = 1'b0;
  endtask

  task automatic mem_pulse(input logic [127:0] d);
    step();
    mem_pulse_now(d);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_v"}, 128'(v_inst), 128'(1'b0));
    check({tag, "_inst"}, inst, 128'h0);
    check({tag, "_err"}, 128'(dn_err), 128'(1'b0));
    check({tag, "_rdy"}, 128'(flit_rdy), 128'(1'b1));
  endtask

  localparam logic [127:0] SEQ_BLK = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
  localparam logic [127:0] DEAD_BLK = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

  initial begin
    logic [127:0] rblk, rmem;
    logic [15:0]  rhdr;
    logic [4:0]   rcmd;

    // Reset state
    repeat (3) step();
    check_reset_outputs("reset");
    rst    = 1'b1;
    mon_en = 1'b1;

    // Back-to-back reply with data 1..8
    send_msg(16'h2C00, SEQ_BLK, 0, 1'b0, '0);
    check("seq_blk", inst, SEQ_BLK);
    step();

    // Same reply with 2-cycle gaps between data flits
    send_msg(16'h2C00, SEQ_BLK, 2, 1'b0, '0);
    check("gap_blk", inst, SEQ_BLK);

    // Non-reply header is dropped, then a good reply follows
    send_msg(16'h0C00, '0, 0, 1'b0, '0);
    send_msg(16'hEDFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 1'b0, '0);

    // Local pulse while idle
    mem_pulse(DEAD_BLK);
    step();

    // Local pulse in the DONE cycle, then one coinciding with the last data flit
    send_msg(16'h6C00, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 1'b0, '0);
    mem_pulse_now(128'hCAFE_F00D_0000_0000_0000_0000_0000_0001);
    step();
    send_msg(16'h2C00, 128'hA5A5_5A5A_A5A5_5A5A_0F0F_F0F0_0F0F_F0F0, 1, 1'b1,
             128'h0BAD_C0DE_0000_0000_0000_0000_0000_0002);
    repeat (2) step();

    // Reset after 4 data flits, then a fresh reply
    step();
    v_flit = 1'b1;
    flit   = 16'h2C00;
    for (int i = 0; i < 4; i++) begin
      step();
      flit = 16'h9000 + 16'(i);
    end
    step();
    v_flit = 1'b0;
    #2 rst = 1'b0;
    exp_last = '0;
    step();
    check_reset_outputs("midrst");
    step();
    rst = 1'b1;
    repeat (3) step();
    send_msg(16'h2C00, 128'h0000_1111_0000_2222_0000_3333_0000_4444, 0, 1'b0, '0);

    // Randomized replies, bad headers and local pulses
    for (int n = 0; n < 24; n++) begin
      rcmd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'b10110;
      rhdr = {2'($urandom), rcmd, 9'($urandom)};
      rblk = {$urandom, $urandom, $urandom, $urandom};
      rmem = {$urandom, $urandom, $urandom, $urandom};
      send_msg(rhdr, rblk, $urandom_range(0, 2), ($urandom_range(0, 4) == 0), rmem);
      if ($urandom_range(0, 2) == 0) mem_pulse({$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (4) step();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
